// File: rtl/led_mode_sequencer_if.sv
// Bundle of LED-source inputs, step controls and LED/mode outputs for the
// LED mode sequencer. The master side drives the controls and sources; the
// slave side (the sequencer) drives the LEDs and the mode status.
interface led_mode_sequencer_if #(
    parameter int NumLeds  = 4,
    parameter int NumModes = 3
);
    localparam int ModeW = (NumModes > 2) ? $clog2(NumModes) : 1;

    logic                         next_i;
    logic                         prev_i;
    logic                         auto_en_i;
    logic [NumModes*NumLeds-1:0]  src_led_i;
    logic [NumLeds-1:0]           led_o;
    logic [ModeW-1:0]             mode_o;
    logic                         show_o;

    modport master (
        output next_i,
        output prev_i,
        output auto_en_i,
        output src_led_i,
        input  led_o,
        input  mode_o,
        input  show_o
    );

    modport slave (
        input  next_i,
        input  prev_i,
        input  auto_en_i,
        input  src_led_i,
        output led_o,
        output mode_o,
        output show_o
    );
endinterface

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: shares the board LEDs between NumModes sources, steps
// through them on next/prev pulses or an auto-advance timer, and shows the
// new mode index on the LEDs for ShowCycles cycles after every change.
module led_mode_sequencer #(
    parameter int NumLeds    = 4,
    parameter int NumModes   = 3,
    parameter int ShowCycles = 50000000,
    parameter int AutoCycles = 500000000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    led_mode_sequencer_if.slave   bus
);
    localparam int ModeW = (NumModes > 2) ? $clog2(NumModes) : 1;
    localparam int ShowW = $clog2(ShowCycles + 1);
    localparam int AutoW = $clog2(AutoCycles);

    localparam logic [ModeW-1:0] ModeLast = ModeW'(NumModes - 1);
    localparam logic [ShowW-1:0] ShowLast = ShowW'(ShowCycles - 1);
    localparam logic [AutoW-1:0] AutoLast = AutoW'(AutoCycles - 1);

    typedef enum logic {
        RUN  = 1'b0,
        SHOW = 1'b1
    } state_e;

    state_e             state_q;
    logic [ModeW-1:0]   mode_q;
    logic [ModeW-1:0]   mode_d;
    logic [ShowW-1:0]   show_cnt_q;
    logic [AutoW-1:0]   auto_cnt_q;
    logic [AutoW-1:0]   auto_cnt_d;
    logic [NumLeds-1:0] led_mux;
    logic               step_next;
    logic               step_prev;
    logic               step;
    logic               auto_fire;

    // Decode step and auto events; pressing both buttons at once is ignored,
    // and any button activity suppresses the auto advance for that cycle.
    always_comb begin
        step_next = bus.next_i & ~bus.prev_i;
        step_prev = bus.prev_i & ~bus.next_i;
        step      = step_next | step_prev;
        auto_fire = (state_q == RUN) & bus.auto_en_i & (auto_cnt_q == AutoLast)
                    & ~bus.next_i & ~bus.prev_i;
    end

    // Next mode index with wrap-around in both directions.
    always_comb begin
        mode_d = mode_q;
        if (step_next || auto_fire) begin
            mode_d = (mode_q == ModeLast) ? '0 : mode_q + ModeW'(1);
        end else if (step_prev) begin
            mode_d = (mode_q == '0) ? ModeLast : mode_q - ModeW'(1);
        end
    end

    // Auto-advance timer: runs only while idling in RUN with auto enabled,
    // restarts from zero after any mode change.
    always_comb begin
        auto_cnt_d = '0;
        if ((state_q == RUN) && bus.auto_en_i && !step && !auto_fire) begin
            auto_cnt_d = (auto_cnt_q == AutoLast) ? '0 : auto_cnt_q + AutoW'(1);
        end
    end

    // RUN/SHOW controller; a step during SHOW restarts the display window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            mode_q     <= '0;
            show_cnt_q <= '0;
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
            case (state_q)
                RUN: begin
                    if (step || auto_fire) begin
                        mode_q     <= mode_d;
                        show_cnt_q <= ShowLast;
                        state_q    <= SHOW;
                    end
                end
                SHOW: begin
                    if (step) begin
                        mode_q     <= mode_d;
                        show_cnt_q <= ShowLast;
                    end else if (show_cnt_q == '0) begin
                        state_q    <= RUN;
                    end else begin
                        show_cnt_q <= show_cnt_q - ShowW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // LED source select: mode index while showing, selected source otherwise.
    always_comb begin
        led_mux = bus.src_led_i[NumLeds-1:0];
        if (state_q == SHOW) begin
            led_mux = NumLeds'(mode_q);
        end else begin
            for (int k = 0; k < NumModes; k++) begin
                if (mode_q == ModeW'(k)) begin
                    led_mux = bus.src_led_i[k*NumLeds +: NumLeds];
                end
            end
        end
    end

    assign bus.led_o  = led_mux;
    assign bus.mode_o = mode_q;
    assign bus.show_o = (state_q == SHOW);
endmodule

// File: tb/tb_led_mode_sequencer.sv
// Testbench for led_mode_sequencer with NumLeds=4, NumModes=3, ShowCycles=4,
// AutoCycles=8. A cycle-level reference model pushes the expected outputs of
// every driven cycle into a queue which is popped and compared mid-cycle.
module tb_led_mode_sequencer;
    localparam int NL = 4;
    localparam int NM = 3;
    localparam int SC = 4;
    localparam int AC = 8;

    typedef struct packed {
        logic [1:0] mode;
        logic       show;
        logic [3:0] led;
    } exp_t;

    logic clk;
    logic rst_n;

    led_mode_sequencer_if #(.NumLeds(NL), .NumModes(NM)) bus ();

    led_mode_sequencer #(
        .NumLeds(NL),
        .NumModes(NM),
        .ShowCycles(SC),
        .AutoCycles(AC)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    int          m_mode;
    int          m_left;
    int          m_acnt;
    logic        auto_lvl;
    logic [11:0] src_lvl;

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_acnt = 0;
    endtask

    // Drive one cycle, push the model's expectation, then compare mid-cycle.
    task automatic drive(input logic n, input logic p);
        exp_t e;
        exp_t got;
        bit   fire;
        bit   sn;
        bit   sp;
        @(posedge clk);
        #1;
        bus.next_i    = n;
        bus.prev_i    = p;
        bus.auto_en_i = auto_lvl;
        bus.src_led_i = src_lvl;
        e.mode = 2'(m_mode);
        e.show = (m_left != 0);
        e.led  = (m_left != 0) ? 4'(m_mode) : src_lvl[m_mode*4 +: 4];
        exp_q.push_back(e);
        sn   = n && !p;
        sp   = p && !n;
        fire = (m_left == 0) && auto_lvl && (m_acnt == AC - 1) && !n && !p;
        if ((m_left == 0) && auto_lvl && !sn && !sp && !fire) m_acnt = (m_acnt + 1) % AC;
        else m_acnt = 0;
        if (sn || fire) m_mode = (m_mode + 1) % NM;
        else if (sp) m_mode = (m_mode + NM - 1) % NM;
        if (sn || sp || fire) m_left = SC;
        else if (m_left > 0) m_left = m_left - 1;
        @(negedge clk);
        e   = exp_q.pop_front();
        got = {bus.mode_o, bus.show_o, bus.led_o};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL sb_cycle t=%0t mode/show/led got %0d/%0b/%h exp %0d/%0b/%h",
                     $time, got.mode, got.show, got.led, e.mode, e.show, e.led);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        auto_lvl      = 1'b0;
        src_lvl       = 12'hCA5;
        bus.next_i    = 1'b0;
        bus.prev_i    = 1'b0;
        bus.auto_en_i = 1'b0;
        bus.src_led_i = src_lvl;
        model_reset();
        #2;
        checks++;
        if ({bus.mode_o, bus.show_o, bus.led_o} !== {2'd0, 1'b0, 4'h5}) begin
            errors++;
            $display("FAIL reset_state mode/show/led got %0d/%0b/%h exp 0/0/5",
                     bus.mode_o, bus.show_o, bus.led_o);
        end
        #6 rst_n = 1'b1;
        repeat (20) drive(1'b0, 1'b0);
        checks++;
        if ({bus.mode_o, bus.show_o, bus.led_o} !== {2'd0, 1'b0, 4'h5}) begin
            errors++;
            $display("FAIL reset_idle mode/show/led got %0d/%0b/%h exp 0/0/5",
                     bus.mode_o, bus.show_o, bus.led_o);
        end
    endtask

    task automatic test_next_wrap();
        logic [1:0] exp_mode [3];
        logic [3:0] exp_led  [3];
        int         show_cnt;
        exp_mode = '{2'd1, 2'd2, 2'd0};
        exp_led  = '{4'hA, 4'hC, 4'h5};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            show_cnt = 0;
            for (int c = 0; c < 9; c++) begin
                drive(1'b0, 1'b0);
                if (bus.show_o === 1'b1) show_cnt++;
            end
            checks++;
            if (show_cnt != SC || bus.mode_o !== exp_mode[i] || bus.led_o !== exp_led[i]) begin
                errors++;
                $display("FAIL next_wrap step %0d show/mode/led got %0d/%0d/%h exp %0d/%0d/%h",
                         i, show_cnt, bus.mode_o, bus.led_o, SC, exp_mode[i], exp_led[i]);
            end
        end
    endtask

    task automatic test_prev_and_both();
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        checks++;
        if ({bus.mode_o, bus.show_o, bus.led_o} !== {2'd2, 1'b1, 4'h2}) begin
            errors++;
            $display("FAIL prev_wrap mode/show/led got %0d/%0b/%h exp 2/1/2",
                     bus.mode_o, bus.show_o, bus.led_o);
        end
        repeat (8) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        checks++;
        if ({bus.mode_o, bus.show_o, bus.led_o} !== {2'd2, 1'b0, 4'hC}) begin
            errors++;
            $display("FAIL both_pulses mode/show/led got %0d/%0b/%h exp 2/0/c",
                     bus.mode_o, bus.show_o, bus.led_o);
        end
    endtask

    task automatic test_window_restart();
        int show_cnt;
        show_cnt = 0;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive((i == 1), 1'b0);
            if (bus.show_o === 1'b1 && i < 7) show_cnt++;
            if (bus.show_o === 1'b1 && i >= 7) show_cnt = show_cnt + 100;
        end
        checks++;
        if (show_cnt != 6 || bus.mode_o !== 2'd1) begin
            errors++;
            $display("FAIL window_restart show_cycles/mode got %0d/%0d exp 6/1",
                     show_cnt, bus.mode_o);
        end
    endtask

    task automatic test_src_follow();
        drive(1'b0, 1'b1);
        repeat (6) drive(1'b0, 1'b0);
        src_lvl = 12'h396;
        drive(1'b0, 1'b0);
        checks++;
        if (bus.led_o !== 4'h6) begin
            errors++;
            $display("FAIL src_follow led got %h exp 6", bus.led_o);
        end
        drive(1'b1, 1'b0);
        src_lvl = 12'hFFF;
        drive(1'b0, 1'b0);
        checks++;
        if (bus.led_o !== 4'h1) begin
            errors++;
            $display("FAIL src_ignored_in_show led got %h exp 1", bus.led_o);
        end
        src_lvl = 12'hCA5;
        repeat (4) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        repeat (6) drive(1'b0, 1'b0);
    endtask

    task automatic test_auto();
        int first;
        int second;
        int last;
        int base;
        first    = -1;
        second   = -1;
        last     = int'(bus.mode_o);
        auto_lvl = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b0);
            if (int'(bus.mode_o) != last) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
                last = int'(bus.mode_o);
            end
        end
        checks++;
        if (first != 8 || second != 20 || last != 2) begin
            errors++;
            $display("FAIL auto_timing first/second/mode got %0d/%0d/%0d exp 8/20/2",
                     first, second, last);
        end
        repeat (7) drive(1'b0, 1'b0);
        base = int'(bus.mode_o);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        repeat (8) drive(1'b0, 1'b0);
        checks++;
        if (int'(bus.mode_o) != (base + 1) % NM) begin
            errors++;
            $display("FAIL auto_vs_manual mode got %0d exp %0d", bus.mode_o, (base + 1) % NM);
        end
        auto_lvl = 1'b0;
        repeat (20) drive(1'b0, 1'b0);
        checks++;
        if (int'(bus.mode_o) != (base + 1) % NM || bus.show_o !== 1'b0) begin
            errors++;
            $display("FAIL auto_disable mode/show got %0d/%0b exp %0d/0",
                     bus.mode_o, bus.show_o, (base + 1) % NM);
        end
    endtask

    task automatic test_reset_mid_show();
        for (int i = 0; i < 3; i++) begin
            if (m_mode != 1) begin
                drive(1'b1, 1'b0);
                repeat (6) drive(1'b0, 1'b0);
            end
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        checks++;
        if ({bus.mode_o, bus.show_o, bus.led_o} !== {2'd2, 1'b1, 4'h2}) begin
            errors++;
            $display("FAIL pre_reset_show mode/show/led got %0d/%0b/%h exp 2/1/2",
                     bus.mode_o, bus.show_o, bus.led_o);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mode_o, bus.show_o, bus.led_o} !== {2'd0, 1'b0, 4'h5}) begin
            errors++;
            $display("FAIL async_reset mode/show/led got %0d/%0b/%h exp 0/0/5",
                     bus.mode_o, bus.show_o, bus.led_o);
        end
        #2 rst_n = 1'b1;
        model_reset();
        repeat (5) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_next_wrap();
        test_prev_and_both();
        test_window_restart();
        test_src_follow();
        test_auto();
        test_reset_mid_show();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
